mastermind_grader: RTL

MASTERMIND_GRADER -- requirements
Module: mastermind_grader

---
 rtl/mastermind_grader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mastermind_grader.sv
// ---------------------------------------------------------------------------
// mastermind_grader
//
// Grades a four-position Mastermind guess against the master pattern.
// Each position holds a 3-bit shape, so all 8 codes are valid shapes.
// Grading is sequential and takes 12 cycles:
//   EXACT : 4 cycles. One position is compared per cycle. A match bumps
//           Znarly. A non-match adds its guess shape and its master shape
//           to two per-shape histograms.
//   COLOR : 8 cycles. One shape per cycle. min(histG[s], histM[s]) is
//           added to Zood.
//   DONE  : GradeDone is held until the requester drops GradeIt.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   GradeIt        level request to grade the presented guess
//   Guess          four 3-bit shapes, position i at bits [3i+2:3i]
//   MasterPattern  four 3-bit shapes, same packing as Guess
//   Znarly         exact matches (right shape, right position)
//   Zood           right shape, wrong position (exact matches excluded)
//   GradeDone      Znarly/Zood valid; held while GradeIt stays high
//   Busy           grading in progress (EXACT or COLOR)
// ---------------------------------------------------------------------------
module mastermind_grader (
    input  logic        clock,
    input  logic        reset,
    input  logic        GradeIt,
    input  logic [11:0] Guess,
    input  logic [11:0] MasterPattern,
    output logic [3:0]  Znarly,
    output logic [3:0]  Zood,
    output logic        GradeDone,
    output logic        Busy
);

    localparam int SHAPE_W = 3;
    localparam int NSHAPES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COLOR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched operands, so that input changes after acceptance are ignored.
    logic [11:0]        guess_l;
    logic [11:0]        master_l;

    // Position index used in EXACT, and shape index used in COLOR.
    logic [1:0]         pos;
    logic [2:0]         shp;

    // Per-shape histograms of the positions that did not match exactly.
    // Each count is at most 4, so 3 bits are enough.
    logic [2:0]         cnt_g [NSHAPES];
    logic [2:0]         cnt_m [NSHAPES];

    logic [3:0]         znarly_q;
    logic [3:0]         zood_q;
    logic               done_q;

    logic [SHAPE_W-1:0] g_shape;
    logic [SHAPE_W-1:0] m_shape;

    // Selects the shape at position i of a packed pattern.
    function automatic logic [SHAPE_W-1:0] shape_at(input logic [11:0] pat,
                                                    input logic [1:0]  i);
        logic [SHAPE_W-1:0] s;
        case (i)
            2'd0:    s = pat[2:0];
            2'd1:    s = pat[5:3];
            2'd2:    s = pat[8:6];
            default: s = pat[11:9];
        endcase
        return s;
    endfunction

    // Returns the smaller of two histogram counts.
    function automatic logic [2:0] min3(input logic [2:0] a,
                                        input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

    assign g_shape = shape_at(guess_l, pos);
    assign m_shape = shape_at(master_l, pos);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (GradeIt)      state_nxt = EXACT;
            EXACT:   if (pos == 2'd3)  state_nxt = COLOR;
            COLOR:   if (shp == 3'd7)  state_nxt = DONE;
            // GradeIt held high in DONE must not start a new grade.
            DONE:    if (!GradeIt)     state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        Busy      = (state == EXACT) || (state == COLOR);
        GradeDone = done_q;
        Znarly    = znarly_q;
        Zood      = zood_q;
    end

    // GradeDone is registered. It rises on the edge that enters DONE and
    // falls on the edge that leaves it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_nxt == DONE);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: operand latches, indices, histograms and score accumulators
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guess_l  <= '0;
            master_l <= '0;
            pos      <= '0;
            shp      <= '0;
            znarly_q <= '0;
            zood_q   <= '0;
            for (int s = 0; s < NSHAPES; s++) begin
                cnt_g[s] <= '0;
                cnt_m[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // The previous result stays visible until a new grade
                    // is accepted.
                    if (GradeIt) begin
                        guess_l  <= Guess;
                        master_l <= MasterPattern;
                        pos      <= '0;
                        shp      <= '0;
                        znarly_q <= '0;
                        zood_q   <= '0;
                        for (int s = 0; s < NSHAPES; s++) begin
                            cnt_g[s] <= '0;
                            cnt_m[s] <= '0;
                        end
                    end
                end

                EXACT: begin
                    // An exact match is marked by leaving it out of both
                    // histograms, so COLOR cannot count it again. In the
                    // else branch the two shapes differ, so the two
                    // increments never hit the same histogram entry.
                    if (g_shape == m_shape) begin
                        znarly_q <= znarly_q + 4'd1;
                    end else begin
                        cnt_g[g_shape] <= cnt_g[g_shape] + 3'd1;
                        cnt_m[m_shape] <= cnt_m[m_shape] + 3'd1;
                    end
                    pos <= pos + 2'd1;
                    shp <= '0;
                end

                COLOR: begin
                    // Znarly + Zood is at most 4, so this sum cannot wrap.
                    zood_q <= zood_q + {1'b0, min3(cnt_g[shp], cnt_m[shp])};
                    shp    <= shp + 3'd1;
                end

                default: begin
                    // DONE keeps every register unchanged.
                end
            endcase
        end
    end

endmodule
